cpack_pattern_matcher: RTL

Registered, handshaked successor of the combinational zero-pattern comparator. It classifies each 32-bit input word into one of six C-Pack patterns: zzzz, zzzx, mmmm, mmmx, mmxx and xxxx. It keeps a parametrised FIFO-replacement dictionary of recent words and emits one right-justified variable-length code per word. It sits between the cache-line word serializer and the bit packer of the compressor.

---
 rtl/cpack_pkg.sv | 24 ++
 rtl/cpack_dict.sv | 62 ++++++
 rtl/cpack_pattern_matcher.sv | 132 +++++++++++++
 3 files changed

// File: rtl/cpack_pkg.sv
// Shared types and constants for the C-Pack pattern matcher: pattern encoding,
// code prefixes and output field widths.
package cpack_pkg;

    typedef enum logic [2:0] {
        ZZZZ = 3'd0,
        ZZZX = 3'd1,
        MMMM = 3'd2,
        MMMX = 3'd3,
        MMXX = 3'd4,
        XXXX = 3'd5
    } pattern_t;

    localparam int unsigned CODE_W = 34;
    localparam int unsigned LEN_W  = 6;

    localparam logic [1:0] PFX_ZZZZ = 2'b00;
    localparam logic [1:0] PFX_XXXX = 2'b01;
    localparam logic [1:0] PFX_MMMM = 2'b10;
    localparam logic [3:0] PFX_MMXX = 4'b1100;
    localparam logic [3:0] PFX_ZZZX = 4'b1101;
    localparam logic [3:0] PFX_MMMX = 4'b1110;

endpackage

// File: rtl/cpack_dict.sv
// FIFO-replacement dictionary of recent words with per-entry match vectors
// for full, upper-24 and upper-16 bit comparisons.
module cpack_dict #(
    parameter int unsigned DICT_DEPTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_clear,
    input  logic                  i_push,
    input  logic [31:0]           i_word,
    output logic [DICT_DEPTH-1:0] o_match_full,
    output logic [DICT_DEPTH-1:0] o_match_hi24,
    output logic [DICT_DEPTH-1:0] o_match_hi16
);

    localparam int unsigned IDX_W = $clog2(DICT_DEPTH);

    logic [31:0]           data_q [DICT_DEPTH];
    logic [DICT_DEPTH-1:0] valid_q, valid_d;
    logic [IDX_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [IDX_W-1:0]      push_idx;

    // A push in the same cycle as a clear lands in entry 0 and survives the flush.
    always_comb begin
        push_idx = i_clear ? '0 : wr_ptr_q;
        valid_d  = i_clear ? '0 : valid_q;
        wr_ptr_d = i_clear ? '0 : wr_ptr_q;
        if (i_push) begin
            valid_d[push_idx] = 1'b1;
            wr_ptr_d          = push_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            valid_q  <= '0;
            wr_ptr_q <= '0;
        end else begin
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            data_q[push_idx] <= i_word;
        end
    end

    // A word presented alongside a clear sees an empty dictionary.
    always_comb begin
        o_match_full = '0;
        o_match_hi24 = '0;
        o_match_hi16 = '0;
        for (int i = 0; i < DICT_DEPTH; i++) begin
            o_match_full[i] = valid_q[i] & ~i_clear & (data_q[i] == i_word);
            o_match_hi24[i] = valid_q[i] & ~i_clear & (data_q[i][31:8] == i_word[31:8]);
            o_match_hi16[i] = valid_q[i] & ~i_clear & (data_q[i][31:16] == i_word[31:16]);
        end
    end

endmodule

// File: rtl/cpack_pattern_matcher.sv
// C-Pack word classifier: dictionary lookup, priority encode, code/length mux
// and a one-deep handshaked output register.
module cpack_pattern_matcher
    import cpack_pkg::*;
#(
    parameter int unsigned DICT_DEPTH = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_clear,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [31:0]       i_word,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [CODE_W-1:0] o_code,
    output logic [LEN_W-1:0]  o_len,
    output pattern_t          o_type
);

    localparam int unsigned IDX_W = $clog2(DICT_DEPTH);

    logic [DICT_DEPTH-1:0] match_full, match_hi24, match_hi16;
    logic                  accept, push;
    pattern_t              pat;
    logic [IDX_W-1:0]      idx;
    logic [CODE_W-1:0]     code;
    logic [LEN_W-1:0]      len;

    logic                  valid_q;
    logic [CODE_W-1:0]     code_q;
    logic [LEN_W-1:0]      len_q;
    pattern_t              type_q;

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [DICT_DEPTH-1:0] vec);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = DICT_DEPTH - 1; i >= 0; i--) begin
            if (vec[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    assign o_ready = ~valid_q | i_ready;
    assign accept  = i_valid & o_ready & ~i_reset;
    assign push    = accept & (pat inside {XXXX, MMXX, MMMX});

    cpack_dict #(
        .DICT_DEPTH (DICT_DEPTH)
    ) u_dict (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clear      (i_clear),
        .i_push       (push),
        .i_word       (i_word),
        .o_match_full (match_full),
        .o_match_hi24 (match_hi24),
        .o_match_hi16 (match_hi16)
    );

    always_comb begin
        pat = XXXX;
        idx = '0;
        if (i_word == 32'd0) begin
            pat = ZZZZ;
        end else if (i_word[31:8] == 24'd0) begin
            pat = ZZZX;
        end else if (|match_full) begin
            pat = MMMM;
            idx = lowest_idx(match_full);
        end else if (|match_hi24) begin
            pat = MMMX;
            idx = lowest_idx(match_hi24);
        end else if (|match_hi16) begin
            pat = MMXX;
            idx = lowest_idx(match_hi16);
        end
    end

    always_comb begin
        code = '0;
        len  = '0;
        unique case (pat)
            ZZZZ: begin
                code = CODE_W'(PFX_ZZZZ);
                len  = LEN_W'(2);
            end
            ZZZX: begin
                code = CODE_W'({PFX_ZZZX, i_word[7:0]});
                len  = LEN_W'(12);
            end
            MMMM: begin
                code = CODE_W'({PFX_MMMM, idx});
                len  = LEN_W'(2 + IDX_W);
            end
            MMMX: begin
                code = CODE_W'({PFX_MMMX, idx, i_word[7:0]});
                len  = LEN_W'(12 + IDX_W);
            end
            MMXX: begin
                code = CODE_W'({PFX_MMXX, idx, i_word[15:0]});
                len  = LEN_W'(20 + IDX_W);
            end
            default: begin
                code = CODE_W'({PFX_XXXX, i_word});
                len  = LEN_W'(34);
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            valid_q <= 1'b0;
            code_q  <= '0;
            len_q   <= '0;
            type_q  <= ZZZZ;
        end else if (accept) begin
            valid_q <= 1'b1;
            code_q  <= code;
            len_q   <= len;
            type_q  <= pat;
        end else if (i_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign o_valid = valid_q;
    assign o_code  = code_q;
    assign o_len   = len_q;
    assign o_type  = type_q;

endmodule
